// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, drives the instruction-memory request
// handshake and defers branch/jump redirects that arrive while a fetch is in flight.
module fetch_unit #(
   parameter int            W          = 32,
   parameter int            AW         = 32,
   parameter logic [AW-1:0] RESET_PC   = '0,
   parameter int            PC_INC     = 4,
   parameter int            ALIGN_BITS = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fetch_start,
   input  logic          pc_write,
   input  logic [AW-1:0] pc_next,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ready,
   input  logic          imem_rvalid,
   input  logic [W-1:0]  imem_rdata,
   output logic [W-1:0]  ir,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] pc_plus,
   output logic          fetch_busy,
   output logic          fetch_done,
   output logic          fetch_fault
);

   // Handshake: the address transfers on a cycle where imem_req && imem_ready;
   // imem_addr is held stable from the first imem_req cycle until that transfer.
   // A response transfers on any WAIT cycle with imem_rvalid (no back-pressure).

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   localparam logic [AW-1:0] ALIGN_MASK = (AW'(1) << ALIGN_BITS) - AW'(1);

   logic [1:0]    state;
   logic          redir_valid;
   logic [AW-1:0] redir_pc;
   logic [AW-1:0] pc_eff;
   logic          misaligned;

   assign imem_addr  = pc;
   assign pc_plus    = pc + AW'(PC_INC);
   assign imem_req   = (state == REQ);
   assign fetch_busy = (state == REQ) || (state == WAIT);

   // The alignment check in IDLE sees a same-cycle pc_write target.
   assign pc_eff     = pc_write ? pc_next : pc;
   assign misaligned = |(pc_eff & ALIGN_MASK);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         ir          <= '0;
         fetch_done  <= 1'b0;
         fetch_fault <= 1'b0;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
      end else begin
         fetch_done  <= 1'b0;
         fetch_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (pc_write) begin
                  pc <= pc_next;
               end
               if (fetch_start) begin
                  if (misaligned) begin
                     fetch_fault <= 1'b1;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            REQ: begin
               if (pc_write) begin
                  redir_valid <= 1'b1;
                  redir_pc    <= pc_next;
               end
               if (imem_ready) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  ir          <= imem_rdata;
                  fetch_done  <= 1'b1;
                  redir_valid <= 1'b0;
                  state       <= IDLE;
                  // A write in the response cycle is newer than any pending redirect.
                  if (pc_write) begin
                     pc <= pc_next;
                  end else if (redir_valid) begin
                     pc <= redir_pc;
                  end else begin
                     pc <= pc_plus;
                  end
               end else if (pc_write) begin
                  redir_valid <= 1'b1;
                  redir_pc    <= pc_next;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
